// File: rtl/l2_request_arbiter_pkg.sv
// Shared types and width defaults for the L1-to-L2 request arbiter.
package l2_request_arbiter_pkg;

  localparam int CPU_WORD_LEN_IN_BITS    = 32;
  localparam int L2_PACKET_WIDTH_IN_BITS = 64;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_ISSUE     = 2'd1,
    ARB_WAIT_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_SRC_ICACHE = 1'b0,
    ARB_SRC_DCACHE = 1'b1
  } arb_src_e;

  function automatic arb_src_e other_src(arb_src_e src);
    return (src == ARB_SRC_ICACHE) ? ARB_SRC_DCACHE : ARB_SRC_ICACHE;
  endfunction

endpackage

// File: rtl/l2_request_arbiter_if.sv
// Bundle of the icache, dcache and L2 request/response signals around the arbiter.
interface l2_request_arbiter_if
  import l2_request_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = CPU_WORD_LEN_IN_BITS,
  parameter int PACKET_WIDTH = L2_PACKET_WIDTH_IN_BITS
);

  logic                    icache_req_valid_in;
  logic [ADDR_WIDTH-1:0]   icache_req_addr_in;
  logic                    icache_req_ready_out;
  logic                    icache_resp_valid_out;
  logic [PACKET_WIDTH-1:0] icache_resp_data_out;

  logic                    dcache_req_valid_in;
  logic [ADDR_WIDTH-1:0]   dcache_req_addr_in;
  logic                    dcache_req_is_write_in;
  logic [PACKET_WIDTH-1:0] dcache_req_wdata_in;
  logic                    dcache_req_ready_out;
  logic                    dcache_resp_valid_out;
  logic [PACKET_WIDTH-1:0] dcache_resp_data_out;

  logic                    l2_req_valid_out;
  logic [ADDR_WIDTH-1:0]   l2_req_addr_out;
  logic                    l2_req_is_write_out;
  logic [PACKET_WIDTH-1:0] l2_req_wdata_out;
  logic                    l2_req_src_out;
  logic                    l2_req_ready_in;
  logic                    l2_resp_valid_in;
  logic [PACKET_WIDTH-1:0] l2_resp_data_in;

  // Arbiter side.
  modport slave (
    input  icache_req_valid_in, icache_req_addr_in,
    output icache_req_ready_out, icache_resp_valid_out, icache_resp_data_out,
    input  dcache_req_valid_in, dcache_req_addr_in, dcache_req_is_write_in, dcache_req_wdata_in,
    output dcache_req_ready_out, dcache_resp_valid_out, dcache_resp_data_out,
    output l2_req_valid_out, l2_req_addr_out, l2_req_is_write_out, l2_req_wdata_out, l2_req_src_out,
    input  l2_req_ready_in, l2_resp_valid_in, l2_resp_data_in
  );

  // Environment side (caches and L2).
  modport master (
    output icache_req_valid_in, icache_req_addr_in,
    input  icache_req_ready_out, icache_resp_valid_out, icache_resp_data_out,
    output dcache_req_valid_in, dcache_req_addr_in, dcache_req_is_write_in, dcache_req_wdata_in,
    input  dcache_req_ready_out, dcache_resp_valid_out, dcache_resp_data_out,
    input  l2_req_valid_out, l2_req_addr_out, l2_req_is_write_out, l2_req_wdata_out, l2_req_src_out,
    output l2_req_ready_in, l2_resp_valid_in, l2_resp_data_in
  );

endinterface

// File: rtl/l2_request_arbiter_priority_picker.sv
// Two-way one-hot picker (bit 0 = icache, bit 1 = dcache).
// L2_ARB_ROUND_ROBIN_EN selects rotating priority; otherwise dcache wins ties.
module l2_arb_priority_picker
  import l2_request_arbiter_pkg::*;
(
  input  logic       icache_valid,
  input  logic       dcache_valid,
`ifdef L2_ARB_ROUND_ROBIN_EN
  input  arb_src_e   prio,
`endif
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: grant gets a default before any branch so no path leaves it unassigned (no latch).
    grant = {dcache_valid, icache_valid};
    if (icache_valid && dcache_valid) begin
`ifdef L2_ARB_ROUND_ROBIN_EN
      grant = (prio == ARB_SRC_ICACHE) ? 2'b01 : 2'b10;
`else
      grant = 2'b10;
`endif
    end
  end

endmodule

// File: rtl/l2_request_arbiter.sv
// Shares the single L2 request port between the L1 icache and dcache, one transaction at a time.
// Optional rotating priority via L2_ARB_ROUND_ROBIN_EN (fixed dcache priority otherwise).
module l2_request_arbiter
  import l2_request_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = CPU_WORD_LEN_IN_BITS,
  parameter int PACKET_WIDTH = L2_PACKET_WIDTH_IN_BITS
) (
  input  logic                clk_in,
  input  logic                reset_in,
  l2_request_arbiter_if.slave bus
);

  arb_state_e              state, state_next;
  logic [1:0]              grant;
  logic                    icache_ready, dcache_ready;
  logic                    accept;
  arb_src_e                accept_src;

  arb_src_e                req_src_q;
  logic [ADDR_WIDTH-1:0]   req_addr_q;
  logic                    req_is_write_q;
  logic [PACKET_WIDTH-1:0] req_wdata_q;
  logic                    icache_resp_valid_q, dcache_resp_valid_q;
  logic [PACKET_WIDTH-1:0] icache_resp_data_q, dcache_resp_data_q;

`ifdef L2_ARB_ROUND_ROBIN_EN
  arb_src_e prio_q;

  always_ff @(posedge clk_in) begin
    if (reset_in)    prio_q <= ARB_SRC_ICACHE;
    else if (accept) prio_q <= other_src(accept_src);
  end
`endif

  l2_arb_priority_picker u_picker (
    .icache_valid (bus.icache_req_valid_in),
    .dcache_valid (bus.dcache_req_valid_in),
`ifdef L2_ARB_ROUND_ROBIN_EN
    .prio         (prio_q),
`endif
    .grant        (grant)
  );

  always_ff @(posedge clk_in) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (reset_in) state <= ARB_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next   = state;
    icache_ready = 1'b0;
    dcache_ready = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        icache_ready = grant[0];
        dcache_ready = grant[1];
        if (grant != 2'b00) state_next = ARB_ISSUE;
      end
      ARB_ISSUE:     if (bus.l2_req_ready_in)  state_next = ARB_WAIT_RESP;
      ARB_WAIT_RESP: if (bus.l2_resp_valid_in) state_next = ARB_IDLE;
      default:       state_next = ARB_IDLE;
    endcase
  end

  // Readies are only ever raised in IDLE, so either one marks a transfer.
  assign accept     = icache_ready | dcache_ready;
  assign accept_src = dcache_ready ? ARB_SRC_DCACHE : ARB_SRC_ICACHE;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      req_src_q           <= ARB_SRC_ICACHE;
      req_addr_q          <= '0;
      req_is_write_q      <= 1'b0;
      req_wdata_q         <= '0;
      icache_resp_valid_q <= 1'b0;
      dcache_resp_valid_q <= 1'b0;
      icache_resp_data_q  <= '0;
      dcache_resp_data_q  <= '0;
    end else begin
      icache_resp_valid_q <= 1'b0;
      dcache_resp_valid_q <= 1'b0;
      if (accept) begin
        req_src_q      <= accept_src;
        req_addr_q     <= dcache_ready ? bus.dcache_req_addr_in : bus.icache_req_addr_in;
        req_is_write_q <= dcache_ready & bus.dcache_req_is_write_in;
        req_wdata_q    <= dcache_ready ? bus.dcache_req_wdata_in : '0;
      end
      if (state == ARB_WAIT_RESP && bus.l2_resp_valid_in) begin
        if (req_src_q == ARB_SRC_DCACHE) begin
          dcache_resp_valid_q <= 1'b1;
          dcache_resp_data_q  <= bus.l2_resp_data_in;
        end else begin
          icache_resp_valid_q <= 1'b1;
          icache_resp_data_q  <= bus.l2_resp_data_in;
        end
      end
    end
  end

  assign bus.icache_req_ready_out  = icache_ready;
  assign bus.dcache_req_ready_out  = dcache_ready;
  assign bus.icache_resp_valid_out = icache_resp_valid_q;
  assign bus.icache_resp_data_out  = icache_resp_data_q;
  assign bus.dcache_resp_valid_out = dcache_resp_valid_q;
  assign bus.dcache_resp_data_out  = dcache_resp_data_q;
  assign bus.l2_req_valid_out      = (state == ARB_ISSUE);
  assign bus.l2_req_addr_out       = req_addr_q;
  assign bus.l2_req_is_write_out   = req_is_write_q;
  assign bus.l2_req_wdata_out      = req_wdata_q;
  assign bus.l2_req_src_out        = req_src_q;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Self-checking bench for l2_request_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level model of the arbitration rules.
module tb_l2_request_arbiter;
  import l2_request_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int PW = 64;

`ifdef L2_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic reset_in;
  always #5 clk_in = ~clk_in;

  l2_request_arbiter_if #(.ADDR_WIDTH(AW), .PACKET_WIDTH(PW)) bus ();

  l2_request_arbiter #(.ADDR_WIDTH(AW), .PACKET_WIDTH(PW)) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Model state: which requester wins the next contention (0 icache, 1 dcache),
  // and the last packet delivered to each requester.
  int          pref;
  logic [PW-1:0] last_idata, last_ddata;

  logic any_out;
  assign any_out = |{bus.icache_req_ready_out, bus.icache_resp_valid_out, bus.icache_resp_data_out,
                     bus.dcache_req_ready_out, bus.dcache_resp_valid_out, bus.dcache_resp_data_out,
                     bus.l2_req_valid_out, bus.l2_req_addr_out, bus.l2_req_is_write_out,
                     bus.l2_req_wdata_out, bus.l2_req_src_out};

  function automatic int pick(bit iv, bit dv);
    if (iv && dv) return RR ? pref : 1;
    if (dv) return 1;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    bus.icache_req_valid_in    = 1'b0;
    bus.icache_req_addr_in     = '0;
    bus.dcache_req_valid_in    = 1'b0;
    bus.dcache_req_addr_in     = '0;
    bus.dcache_req_is_write_in = 1'b0;
    bus.dcache_req_wdata_in    = '0;
    bus.l2_req_ready_in        = 1'b0;
    bus.l2_resp_valid_in       = 1'b0;
    bus.l2_resp_data_in        = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_in = 1'b1;
    tick();
    tick();
    reset_in   = 1'b0;
    pref       = 0;
    last_idata = '0;
    last_ddata = '0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (any_out !== 1'b0) begin errors++; $display("FAIL reset_outputs got=%b exp=0", any_out); end
    tick();
    tick();
    checks++;
    if (any_out !== 1'b0) begin errors++; $display("FAIL idle_outputs got=%b exp=0", any_out); end
  endtask

  task automatic test_icache_read();
    bus.icache_req_valid_in = 1'b1;
    bus.icache_req_addr_in  = 32'h0000_1000;
    #1;
    checks++;
    if ({bus.dcache_req_ready_out, bus.icache_req_ready_out} !== 2'b01) begin
      errors++; $display("FAIL ird_ready got=%b exp=01", {bus.dcache_req_ready_out, bus.icache_req_ready_out});
    end
    tick();
    bus.icache_req_valid_in = 1'b0;
    bus.l2_req_ready_in     = 1'b1;
    #1;
    checks++;
    if ({bus.l2_req_valid_out, bus.l2_req_src_out, bus.l2_req_is_write_out, bus.l2_req_addr_out} !==
        {1'b1, 1'b0, 1'b0, 32'h0000_1000}) begin
      errors++; $display("FAIL ird_l2req got v=%b s=%b w=%b a=%h exp v=1 s=0 w=0 a=00001000",
                         bus.l2_req_valid_out, bus.l2_req_src_out, bus.l2_req_is_write_out, bus.l2_req_addr_out);
    end
    tick();
    bus.l2_req_ready_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({bus.l2_req_valid_out, bus.icache_resp_valid_out, bus.dcache_resp_valid_out} !== 3'b000) begin
        errors++; $display("FAIL ird_wait got=%b exp=000",
                           {bus.l2_req_valid_out, bus.icache_resp_valid_out, bus.dcache_resp_valid_out});
      end
      tick();
    end
    bus.l2_resp_valid_in = 1'b1;
    bus.l2_resp_data_in  = 64'hDEAD_BEEF_0000_0001;
    tick();
    bus.l2_resp_valid_in = 1'b0;
    bus.l2_resp_data_in  = '0;
    #1;
    checks++;
    if ({bus.icache_resp_valid_out, bus.dcache_resp_valid_out, bus.icache_resp_data_out} !==
        {1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001}) begin
      errors++; $display("FAIL ird_resp got iv=%b dv=%b d=%h exp iv=1 dv=0 d=deadbeef00000001",
                         bus.icache_resp_valid_out, bus.dcache_resp_valid_out, bus.icache_resp_data_out);
    end
    last_idata = 64'hDEAD_BEEF_0000_0001;
    tick();
    checks++;
    if ({bus.icache_resp_valid_out, bus.dcache_resp_valid_out} !== 2'b00) begin
      errors++; $display("FAIL ird_single_pulse got=%b exp=00", {bus.icache_resp_valid_out, bus.dcache_resp_valid_out});
    end
  endtask

  task automatic test_dcache_write_stall();
    int pulses;
    bus.dcache_req_valid_in    = 1'b1;
    bus.dcache_req_addr_in     = 32'h0000_2040;
    bus.dcache_req_is_write_in = 1'b1;
    bus.dcache_req_wdata_in    = 64'h1234;
    #1;
    checks++;
    if ({bus.dcache_req_ready_out, bus.icache_req_ready_out} !== 2'b10) begin
      errors++; $display("FAIL dwr_ready got=%b exp=10", {bus.dcache_req_ready_out, bus.icache_req_ready_out});
    end
    tick();
    bus.dcache_req_valid_in    = 1'b0;
    bus.dcache_req_addr_in     = 32'hFFFF_FFFF;
    bus.dcache_req_is_write_in = 1'b0;
    bus.dcache_req_wdata_in    = '1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({bus.l2_req_valid_out, bus.l2_req_src_out, bus.l2_req_is_write_out, bus.l2_req_addr_out, bus.l2_req_wdata_out} !==
          {1'b1, 1'b1, 1'b1, 32'h0000_2040, 64'h1234}) begin
        errors++; $display("FAIL dwr_stall%0d got v=%b s=%b w=%b a=%h d=%h exp v=1 s=1 w=1 a=00002040 d=1234", i,
                           bus.l2_req_valid_out, bus.l2_req_src_out, bus.l2_req_is_write_out,
                           bus.l2_req_addr_out, bus.l2_req_wdata_out);
      end
      tick();
    end
    bus.l2_req_ready_in = 1'b1;
    tick();
    bus.l2_req_ready_in  = 1'b0;
    bus.l2_resp_valid_in = 1'b1;
    bus.l2_resp_data_in  = 64'h0BAD_F00D_0000_0000;
    tick();
    bus.l2_resp_valid_in = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.dcache_resp_valid_out === 1'b1) pulses++;
      if (bus.icache_resp_valid_out !== 1'b0) pulses += 100;
      tick();
    end
    last_ddata = 64'h0BAD_F00D_0000_0000;
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL dwr_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_spurious();
    bus.l2_resp_valid_in = 1'b1;
    bus.l2_resp_data_in  = 64'h5555_5555_5555_5555;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({bus.icache_resp_valid_out, bus.dcache_resp_valid_out, bus.l2_req_valid_out} !== 3'b000) begin
        errors++; $display("FAIL spur_idle got=%b exp=000",
                           {bus.icache_resp_valid_out, bus.dcache_resp_valid_out, bus.l2_req_valid_out});
      end
    end
    bus.l2_resp_valid_in    = 1'b0;
    bus.icache_req_valid_in = 1'b1;
    bus.icache_req_addr_in  = 32'h0000_3000;
    tick();
    bus.icache_req_valid_in = 1'b0;
    bus.l2_resp_valid_in    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({bus.icache_resp_valid_out, bus.dcache_resp_valid_out, bus.l2_req_valid_out} !== 3'b001) begin
        errors++; $display("FAIL spur_issue got=%b exp=001",
                           {bus.icache_resp_valid_out, bus.dcache_resp_valid_out, bus.l2_req_valid_out});
      end
    end
    bus.l2_resp_valid_in = 1'b0;
    bus.l2_req_ready_in  = 1'b1;
    tick();
    bus.l2_req_ready_in  = 1'b0;
    bus.l2_resp_valid_in = 1'b1;
    bus.l2_resp_data_in  = 64'h0123_4567_89AB_CDEF;
    tick();
    bus.l2_resp_valid_in = 1'b0;
    #1;
    checks++;
    if ({bus.icache_resp_valid_out, bus.dcache_resp_valid_out, bus.icache_resp_data_out} !==
        {1'b1, 1'b0, 64'h0123_4567_89AB_CDEF}) begin
      errors++; $display("FAIL spur_resp got iv=%b dv=%b d=%h exp iv=1 dv=0 d=0123456789abcdef",
                         bus.icache_resp_valid_out, bus.dcache_resp_valid_out, bus.icache_resp_data_out);
    end
    last_idata = 64'h0123_4567_89AB_CDEF;
    tick();
  endtask

  task automatic test_back_to_back();
    bus.icache_req_valid_in = 1'b1;
    bus.icache_req_addr_in  = 32'h0000_4000;
    tick();
    bus.icache_req_addr_in = 32'h0000_4040;
    bus.l2_req_ready_in    = 1'b1;
    tick();
    bus.l2_req_ready_in = 1'b0;
    #1;
    checks++;
    if (bus.icache_req_ready_out !== 1'b0) begin
      errors++; $display("FAIL b2b_wait_ready got=%b exp=0", bus.icache_req_ready_out);
    end
    bus.l2_resp_valid_in = 1'b1;
    bus.l2_resp_data_in  = 64'hAAAA_0000_BBBB_0001;
    tick();
    bus.l2_resp_valid_in = 1'b0;
    #1;
    checks++;
    if ({bus.icache_resp_valid_out, bus.icache_req_ready_out} !== 2'b11) begin
      errors++; $display("FAIL b2b_same_cycle got pulse/ready=%b exp=11",
                         {bus.icache_resp_valid_out, bus.icache_req_ready_out});
    end
    last_idata = 64'hAAAA_0000_BBBB_0001;
    tick();
    bus.icache_req_valid_in = 1'b0;
    bus.l2_req_ready_in     = 1'b1;
    #1;
    checks++;
    if ({bus.l2_req_valid_out, bus.l2_req_addr_out} !== {1'b1, 32'h0000_4040}) begin
      errors++; $display("FAIL b2b_second_req got v=%b a=%h exp v=1 a=00004040",
                         bus.l2_req_valid_out, bus.l2_req_addr_out);
    end
    tick();
    bus.l2_req_ready_in  = 1'b0;
    bus.l2_resp_valid_in = 1'b1;
    bus.l2_resp_data_in  = 64'h2;
    tick();
    bus.l2_resp_valid_in = 1'b0;
    #1;
    checks++;
    if ({bus.icache_resp_valid_out, bus.icache_resp_data_out} !== {1'b1, 64'h2}) begin
      errors++; $display("FAIL b2b_second_resp got v=%b d=%h exp v=1 d=2",
                         bus.icache_resp_valid_out, bus.icache_resp_data_out);
    end
    last_idata = 64'h2;
    tick();
  endtask

  task automatic test_contention();
    int exp_order[4];
    do_reset();
    exp_order = RR ? '{0, 1, 0, 1} : '{1, 1, 1, 1};
    bus.icache_req_valid_in    = 1'b1;
    bus.icache_req_addr_in     = 32'h0000_5000;
    bus.dcache_req_valid_in    = 1'b1;
    bus.dcache_req_addr_in     = 32'h0000_6000;
    bus.dcache_req_is_write_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_rdy;
      exp_rdy = (exp_order[k] == 1) ? 2'b10 : 2'b01;
      #1;
      checks++;
      if ({bus.dcache_req_ready_out, bus.icache_req_ready_out} !== exp_rdy) begin
        errors++; $display("FAIL cont%0d_ready got=%b exp=%b", k,
                           {bus.dcache_req_ready_out, bus.icache_req_ready_out}, exp_rdy);
      end
      tick();
      bus.l2_req_ready_in = 1'b1;
      #1;
      checks++;
      if ({bus.l2_req_valid_out, bus.l2_req_src_out, bus.dcache_req_ready_out, bus.icache_req_ready_out} !==
          {1'b1, exp_order[k] == 1, 2'b00}) begin
        errors++; $display("FAIL cont%0d_src got v=%b s=%b rdy=%b exp v=1 s=%0d rdy=00", k,
                           bus.l2_req_valid_out, bus.l2_req_src_out,
                           {bus.dcache_req_ready_out, bus.icache_req_ready_out}, exp_order[k]);
      end
      tick();
      bus.l2_req_ready_in  = 1'b0;
      bus.l2_resp_valid_in = 1'b1;
      bus.l2_resp_data_in  = 64'(k + 10);
      tick();
      bus.l2_resp_valid_in = 1'b0;
      if (k == 3) begin
        bus.icache_req_valid_in = 1'b0;
        bus.dcache_req_valid_in = 1'b0;
      end
      #1;
      checks++;
      if ({bus.dcache_resp_valid_out, bus.icache_resp_valid_out} !== exp_rdy) begin
        errors++; $display("FAIL cont%0d_resp got=%b exp=%b", k,
                           {bus.dcache_resp_valid_out, bus.icache_resp_valid_out}, exp_rdy);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.dcache_req_valid_in = 1'b1;
    bus.dcache_req_addr_in  = 32'h0000_7000;
    tick();
    bus.dcache_req_valid_in = 1'b0;
    bus.l2_req_ready_in     = 1'b1;
    tick();
    bus.l2_req_ready_in = 1'b0;
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    pref     = 0;
    #1;
    checks++;
    if (any_out !== 1'b0) begin errors++; $display("FAIL rstmid_outputs got=%b exp=0", any_out); end
    bus.l2_resp_valid_in = 1'b1;
    bus.l2_resp_data_in  = 64'hFEED;
    tick();
    bus.l2_resp_valid_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({bus.icache_resp_valid_out, bus.dcache_resp_valid_out} !== 2'b00) begin
        errors++; $display("FAIL rstmid_no_pulse got=%b exp=00", {bus.icache_resp_valid_out, bus.dcache_resp_valid_out});
      end
      tick();
    end
    bus.icache_req_valid_in = 1'b1;
    bus.icache_req_addr_in  = 32'h0000_8000;
    #1;
    checks++;
    if (bus.icache_req_ready_out !== 1'b1) begin
      errors++; $display("FAIL rstmid_next_accept got=%b exp=1", bus.icache_req_ready_out);
    end
    tick();
    bus.icache_req_valid_in = 1'b0;
    bus.l2_req_ready_in     = 1'b1;
    tick();
    bus.l2_req_ready_in  = 1'b0;
    bus.l2_resp_valid_in = 1'b1;
    bus.l2_resp_data_in  = 64'h8;
    tick();
    bus.l2_resp_valid_in = 1'b0;
    #1;
    checks++;
    if ({bus.icache_resp_valid_out, bus.icache_resp_data_out} !== {1'b1, 64'h8}) begin
      errors++; $display("FAIL rstmid_next_resp got v=%b d=%h exp v=1 d=8",
                         bus.icache_resp_valid_out, bus.icache_resp_data_out);
    end
    tick();
  endtask

  task automatic test_random(int n);
    do_reset();
    for (int t = 0; t < n; t++) begin
      bit            iv, dv, dw;
      int            w, stall, lat;
      logic [AW-1:0] ia, da, exp_addr;
      logic [PW-1:0] dwd, rd, exp_wd, exp_id, exp_dd;
      logic [1:0]    exp_rdy;
      iv = 1'($urandom_range(0, 1));
      dv = 1'($urandom_range(0, 1));
      if (!iv && !dv) iv = 1'b1;
      ia  = $urandom;
      da  = $urandom;
      dw  = 1'($urandom_range(0, 1));
      dwd = {$urandom, $urandom};
      bus.icache_req_valid_in    = iv;
      bus.icache_req_addr_in     = ia;
      bus.dcache_req_valid_in    = dv;
      bus.dcache_req_addr_in     = da;
      bus.dcache_req_is_write_in = dw;
      bus.dcache_req_wdata_in    = dwd;
      w        = pick(iv, dv);
      exp_rdy  = (w == 1) ? 2'b10 : 2'b01;
      exp_addr = (w == 1) ? da : ia;
      exp_wd   = (w == 1) ? dwd : '0;
      #1;
      checks++;
      if ({bus.dcache_req_ready_out, bus.icache_req_ready_out} !== exp_rdy) begin
        errors++; $display("FAIL rnd%0d_ready got=%b exp=%b", t,
                           {bus.dcache_req_ready_out, bus.icache_req_ready_out}, exp_rdy);
      end
      tick();
      pref = 1 - w;
      bus.icache_req_valid_in = 1'b0;
      bus.dcache_req_valid_in = 1'b0;
      bus.icache_req_addr_in  = $urandom;
      bus.dcache_req_addr_in  = $urandom;
      bus.dcache_req_wdata_in = {$urandom, $urandom};
      stall = $urandom_range(0, 3);
      for (int s = 0; s <= stall; s++) begin
        bus.l2_req_ready_in  = (s == stall);
        bus.l2_resp_valid_in = (s == stall) ? 1'b0 : 1'($urandom_range(0, 1));
        bus.l2_resp_data_in  = {$urandom, $urandom};
        #1;
        checks++;
        if ({bus.l2_req_valid_out, bus.l2_req_src_out, bus.l2_req_addr_out, bus.l2_req_is_write_out,
             bus.l2_req_wdata_out, bus.icache_resp_valid_out, bus.dcache_resp_valid_out} !==
            {1'b1, w == 1, exp_addr, dw & (w == 1), exp_wd, 2'b00}) begin
          errors++; $display("FAIL rnd%0d_l2req got v=%b s=%b a=%h w=%b d=%h exp s=%0d a=%h w=%b d=%h", t,
                             bus.l2_req_valid_out, bus.l2_req_src_out, bus.l2_req_addr_out,
                             bus.l2_req_is_write_out, bus.l2_req_wdata_out, w, exp_addr, dw & (w == 1), exp_wd);
        end
        tick();
      end
      bus.l2_req_ready_in  = 1'b0;
      bus.l2_resp_valid_in = 1'b0;
      lat = $urandom_range(0, 3);
      for (int l = 0; l < lat; l++) begin
        #1;
        checks++;
        if ({bus.l2_req_valid_out, bus.icache_resp_valid_out, bus.dcache_resp_valid_out} !== 3'b000) begin
          errors++; $display("FAIL rnd%0d_wait got=%b exp=000", t,
                             {bus.l2_req_valid_out, bus.icache_resp_valid_out, bus.dcache_resp_valid_out});
        end
        tick();
      end
      rd = {$urandom, $urandom};
      bus.l2_resp_valid_in = 1'b1;
      bus.l2_resp_data_in  = rd;
      tick();
      bus.l2_resp_valid_in = 1'b0;
      bus.l2_resp_data_in  = {$urandom, $urandom};
      if (w == 1) last_ddata = rd;
      else        last_idata = rd;
      exp_id = last_idata;
      exp_dd = last_ddata;
      #1;
      checks++;
      if ({bus.dcache_resp_valid_out, bus.icache_resp_valid_out, bus.icache_resp_data_out, bus.dcache_resp_data_out} !==
          {exp_rdy, exp_id, exp_dd}) begin
        errors++; $display("FAIL rnd%0d_resp got v=%b id=%h dd=%h exp v=%b id=%h dd=%h", t,
                           {bus.dcache_resp_valid_out, bus.icache_resp_valid_out},
                           bus.icache_resp_data_out, bus.dcache_resp_data_out, exp_rdy, exp_id, exp_dd);
      end
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before the summary line");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in = 1'b1;
    idle_inputs();
    test_reset();
    test_icache_read();
    test_dcache_write_stall();
    test_spurious();
    test_back_to_back();
    test_contention();
    test_reset_mid();
    test_random(60);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l2_request_arbiter.md
Name: l2_request_arbiter

Overview:
Shares the single request port of l2_unified_cache between the L1 instruction cache and the L1 data cache. Accepts one request at a time from either requester and forwards it to L2. Holds ownership until L2 returns the response, then routes the response back to the owning requester. Sits between l1_insts_cache / L1 dcache and l2_unified_cache inside pumpkin_cpu_top.

Parameters:
ADDR_WIDTH, 32, request address width (CPU word length)
PACKET_WIDTH, 64, L2 packet payload width in bits

Ports:
clk_in  input  1  clock
reset_in  input  1  synchronous active-high reset
icache_req_valid_in  input  1  icache request pending
icache_req_addr_in  input  ADDR_WIDTH  icache fill address
icache_req_ready_out  output  1  icache request accepted this cycle
icache_resp_valid_out  output  1  one-cycle pulse, icache response valid
icache_resp_data_out  output  PACKET_WIDTH  icache response packet
dcache_req_valid_in  input  1  dcache request pending
dcache_req_addr_in  input  ADDR_WIDTH  dcache address
dcache_req_is_write_in  input  1  1 = write, 0 = read
dcache_req_wdata_in  input  PACKET_WIDTH  write packet
dcache_req_ready_out  output  1  dcache request accepted this cycle
dcache_resp_valid_out  output  1  one-cycle pulse, dcache response valid (read data or write ack)
dcache_resp_data_out  output  PACKET_WIDTH  dcache response packet
l2_req_valid_out  output  1  request to L2 valid
l2_req_addr_out  output  ADDR_WIDTH  forwarded address
l2_req_is_write_out  output  1  forwarded write flag
l2_req_wdata_out  output  PACKET_WIDTH  forwarded write packet
l2_req_src_out  output  1  0 = icache, 1 = dcache
l2_req_ready_in  input  1  L2 accepts request
l2_resp_valid_in  input  1  L2 response valid
l2_resp_data_in  input  PACKET_WIDTH  L2 response packet

Behaviour:
- Clock is clk_in. reset_in is synchronous and active-high.
- FSM has three states: IDLE, ISSUE, WAIT_RESP. Reset puts the FSM in IDLE.
- Reset clears all outputs to 0, clears the latched request registers, and sets the priority pointer to icache.
- IDLE:
  - The picker selects a winner among the asserted valids.
  - The winner's req_ready_out is combinationally 1 in the same cycle; the loser's is 0.
  - A transfer happens when valid & ready. On transfer, latch addr, is_write, wdata and src (icache is_write forced to 0, wdata forced to 0), then go to ISSUE.
  - If no valid is asserted, stay in IDLE with all ready_out at 0.
- ISSUE:
  - l2_req_valid_out=1 and the latched fields are held stable.
  - When l2_req_ready_in=1, go to WAIT_RESP next cycle; otherwise hold indefinitely.
  - All req_ready_out are 0.
- WAIT_RESP:
  - On l2_resp_valid_in=1, register l2_resp_data_in.
  - Pulse the owner's resp_valid_out for exactly one cycle, on the next cycle. Response latency through the arbiter is 1 cycle.
  - Return to IDLE in that same next cycle.
- Latency:
  - Earliest l2_req_valid_out is the cycle after acceptance.
  - Back-to-back: a new request can be accepted in the cycle the previous resp_valid_out pulses.
- Only one transaction is outstanding at a time.
- l2_resp_valid_in outside WAIT_RESP is ignored and no response is produced.
- The non-owner's resp_valid_out stays 0 throughout.
- resp_data_out holds its last value between pulses and is only meaningful while resp_valid_out=1.
- A dcache write completes with a response pulse; the data on that pulse is whatever L2 returns and is don't-care.
- A requester may drop valid before it is granted; the arbiter does not latch anything until the transfer.
- Reset mid-transaction aborts it: no response pulse is produced and any late L2 response is ignored.
- The priority pointer updates only on a transfer.

Optional Feature:
Macro L2_ARB_ROUND_ROBIN_EN.
- Defined: rotating priority. After a grant to X, the other requester wins the next cycle in which both valids are asserted. The pointer is reset to icache.
- Undefined: fixed priority, dcache always wins when both are valid. The pointer register is not built.
- Single-requester behaviour is identical in both builds.

Decomposition:
- Shared package / parameters.h holds:
  - FSM state encodings: ARB_IDLE, ARB_ISSUE, ARB_WAIT_RESP.
  - Source IDs: ARB_SRC_ICACHE=0, ARB_SRC_DCACHE=1.
  - Width macros CPU_WORD_LEN_IN_BITS and L2_PACKET_WIDTH_IN_BITS as parameter defaults.
- One sub-module, l2_arb_priority_picker: combinational 2-way picker taking two valids and the pointer, giving a one-hot grant. The macro selects its mode.

Test Plan:
- Single icache read, addr 0x0000_1000, l2_req_ready_in=1, L2 responds 3 cycles later with 0xDEAD_BEEF_0000_0001:
  - l2_req_valid_out asserts 1 cycle after acceptance with src=0, is_write=0.
  - icache_resp_valid_out pulses once, 1 cycle after l2_resp_valid_in, with the same data.
  - dcache_resp_valid_out stays 0.
- Dcache write, addr 0x0000_2040, wdata 0x1234, L2 holds l2_req_ready_in=0 for 4 cycles:
  - l2_req_valid_out, addr and wdata are held stable all 4 cycles.
  - Exactly one dcache_resp_valid_out pulse follows.
- Both valid continuously for 4 transactions:
  - With L2_ARB_ROUND_ROBIN_EN, grant order is icache, dcache, icache, dcache.
  - Without it, dcache is granted all 4 times.
- Spurious l2_resp_valid_in in IDLE and in ISSUE:
  - No resp_valid_out pulse.
  - FSM is unaffected.
- reset_in asserted for 1 cycle in WAIT_RESP, then L2 responds:
  - All outputs are 0 the cycle after reset.
  - No response pulse is produced.
  - A next icache request is accepted normally.
- Back-to-back: a second icache request is held valid during the first response:
  - Acceptance occurs in the same cycle as the first resp_valid_out pulse.
